// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer that shares the memory access
// unit between the instruction-fetch port and the load/store data port.
// Each access runs a fixed four-state sequence: IDLE grant, two enable cycles
// (ISSUE, CAPTURE), then a one-cycle DONE pulse to the granted port.

package mem_arbiter_pkg;
  localparam logic [1:0] OP_BYTE = 2'd0;
  localparam logic [1:0] OP_HALF = 2'd1;
  localparam logic [1:0] OP_WORD = 2'd2;

  typedef struct packed {
    logic       is_write;
    logic       is_unsigned;
    logic [1:0] op_size;
  } mem_microcode_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit RESET_PRIORITY = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           fetch_req,
  input  logic [31:0]    fetch_addr,
  output logic           fetch_done,
  output logic [31:0]    fetch_data,
  output logic [2:0]     fetch_fault_num,
  input  logic           data_req,
  input  mem_microcode_t data_microcode,
  input  logic [31:0]    data_addr,
  input  logic [31:0]    data_wdata,
  output logic           data_done,
  output logic [31:0]    data_rdata,
  output logic [2:0]     data_fault_num,
  output logic           mem_enable_n,
  output mem_microcode_t mem_microcode,
  output logic [31:0]    mem_addr,
  output logic [31:0]    mem_in,
  input  logic [31:0]    mem_out,
  input  logic [2:0]     mem_fault_num
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Instruction fetches are always unsigned word reads.
  localparam mem_microcode_t FETCH_MICROCODE = '{is_write: 1'b0, is_unsigned: 1'b1, op_size: OP_WORD};

  state_t state;
  state_t state_next;
  logic   owner_fetch;
  logic   ptr_fetch;
  logic   grant;
  logic   grant_fetch;

  // Next-state, grant selection and state-decoded outputs.
  always_comb begin
    state_next   = state;
    grant        = 1'b0;
    grant_fetch  = 1'b0;
    mem_enable_n = 1'b1;
    fetch_done   = 1'b0;
    data_done    = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req || data_req) begin
          grant       = 1'b1;
          grant_fetch = (fetch_req && data_req) ? ptr_fetch : fetch_req;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        mem_enable_n = 1'b0;
        state_next   = CAPTURE;
      end
      CAPTURE: begin
        mem_enable_n = 1'b0;
        state_next   = DONE;
      end
      DONE: begin
        fetch_done = owner_fetch;
        data_done  = ~owner_fetch;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops any in-flight access without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Owner and round-robin pointer: the pointer always names the port not just granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_fetch <= 1'b0;
      ptr_fetch   <= RESET_PRIORITY;
    end else if (grant) begin
      owner_fetch <= grant_fetch;
      ptr_fetch   <= ~grant_fetch;
    end
  end

  // Memory-unit inputs are registered at grant so they stay stable through DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr      <= '0;
      mem_in        <= '0;
      mem_microcode <= '0;
    end else if (grant) begin
      if (grant_fetch) begin
        mem_addr      <= fetch_addr;
        mem_in        <= '0;
        mem_microcode <= FETCH_MICROCODE;
      end else begin
        mem_addr      <= data_addr;
        mem_in        <= data_wdata;
        mem_microcode <= data_microcode;
      end
    end
  end

  // Result capture on the CAPTURE exit edge into the owner's registers only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_data      <= '0;
      fetch_fault_num <= '0;
      data_rdata      <= '0;
      data_fault_num  <= '0;
    end else if (state == CAPTURE) begin
      if (owner_fetch) begin
        fetch_data      <= mem_out;
        fetch_fault_num <= mem_fault_num;
      end else begin
        data_rdata      <= mem_out;
        data_fault_num  <= mem_fault_num;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with literal expectations, plus a
// timestamp-based transaction model compared against the DUT every cycle.

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           fetch_req;
  logic [31:0]    fetch_addr;
  logic           fetch_done;
  logic [31:0]    fetch_data;
  logic [2:0]     fetch_fault_num;
  logic           data_req;
  mem_microcode_t data_microcode;
  logic [31:0]    data_addr;
  logic [31:0]    data_wdata;
  logic           data_done;
  logic [31:0]    data_rdata;
  logic [2:0]     data_fault_num;
  logic           mem_enable_n;
  mem_microcode_t mem_microcode;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_in;
  logic [31:0]    mem_out;
  logic [2:0]     mem_fault_num;

  logic [31:0]    fixed_out;
  logic           auto_mem;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RESET_PRIORITY(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
    .fetch_data(fetch_data), .fetch_fault_num(fetch_fault_num),
    .data_req(data_req), .data_microcode(data_microcode), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_done(data_done), .data_rdata(data_rdata),
    .data_fault_num(data_fault_num), .mem_enable_n(mem_enable_n),
    .mem_microcode(mem_microcode), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_out(mem_out), .mem_fault_num(mem_fault_num)
  );

  // Simple memory stand-in: either a fixed word or an address-derived word.
  always_comb begin
    mem_out = auto_mem ? (mem_addr ^ 32'hA5A5_0000) : fixed_out;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Model: an access granted on edge g has its enable window in the two cycles
  // after g, captures on edge g+2, pulses done in cycle g+2, and the port is
  // free to grant again on edge g+4.
  int unsigned    edge_n = 0;
  int unsigned    m_g = 0;
  bit             m_active = 0;
  bit             m_owner_fetch = 0;
  bit             m_ptr_fetch = 0;
  logic [31:0]    e_addr = 0, e_in = 0, e_fdata = 0, e_drdata = 0;
  logic [3:0]     e_mc = 0;
  logic [2:0]     e_ffault = 0, e_dfault = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        edge_n = 0; m_g = 0; m_active = 0; m_owner_fetch = 0; m_ptr_fetch = 1'b0;
        e_addr = 0; e_in = 0; e_mc = 0; e_fdata = 0; e_drdata = 0; e_ffault = 0; e_dfault = 0;
      end else begin
        edge_n++;
        if (m_active && edge_n == m_g + 2) begin
          if (m_owner_fetch) begin
            e_fdata = mem_out; e_ffault = mem_fault_num;
          end else begin
            e_drdata = mem_out; e_dfault = mem_fault_num;
          end
        end
        if (m_active && edge_n == m_g + 4) m_active = 0;
        if (!m_active && (fetch_req || data_req)) begin
          m_owner_fetch = (fetch_req && data_req) ? m_ptr_fetch : fetch_req;
          m_ptr_fetch   = !m_owner_fetch;
          e_addr = m_owner_fetch ? fetch_addr : data_addr;
          e_in   = m_owner_fetch ? 32'd0 : data_wdata;
          e_mc   = m_owner_fetch ? 4'b0110 : data_microcode;
          m_g = edge_n;
          m_active = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    bit win, dn;
    if (reset_n === 1'b1) begin
      win = m_active && (edge_n == m_g || edge_n == m_g + 1);
      dn  = m_active && (edge_n == m_g + 2);
      checkOutput("model mem_enable_n", 32'(mem_enable_n), 32'(!win));
      checkOutput("model fetch_done", 32'(fetch_done), 32'(dn && m_owner_fetch));
      checkOutput("model data_done", 32'(data_done), 32'(dn && !m_owner_fetch));
      checkOutput("model one_done", 32'(fetch_done && data_done), 32'd0);
      checkOutput("model mem_addr", mem_addr, e_addr);
      checkOutput("model mem_in", mem_in, e_in);
      checkOutput("model mem_microcode", 32'(mem_microcode), 32'(e_mc));
      checkOutput("model fetch_data", fetch_data, e_fdata);
      checkOutput("model fetch_fault", 32'(fetch_fault_num), 32'(e_ffault));
      checkOutput("model data_rdata", data_rdata, e_drdata);
      checkOutput("model data_fault", 32'(data_fault_num), 32'(e_dfault));
    end
  end

  task automatic waitCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic f_req, input logic [31:0] f_addr,
                               input logic d_req, input logic [3:0] d_mc,
                               input logic [31:0] d_addr, input logic [31:0] d_wdata,
                               input logic [31:0] out_val, input logic [2:0] fault,
                               input logic use_auto);
    fetch_req      = f_req;
    fetch_addr     = f_addr;
    data_req       = d_req;
    data_microcode = d_mc;
    data_addr      = d_addr;
    data_wdata     = d_wdata;
    fixed_out      = out_val;
    mem_fault_num  = fault;
    auto_mem       = use_auto;
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 4'h0, 0, 0, 0, 3'd0, 0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset mem_enable_n", 32'(mem_enable_n), 32'd1);
    checkOutput("reset dones", 32'({fetch_done, data_done}), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset fetch_data", fetch_data, 32'd0);
    reset_n = 1'b1;

    // Fetch only
    applyStimulus(1, 32'h0000_0100, 0, 4'h0, 0, 0, 32'h00A0_0093, 3'd0, 0);
    waitCycle();
    checkOutput("fetch k0 enable_n", 32'(mem_enable_n), 32'd0);
    checkOutput("fetch k0 mem_addr", mem_addr, 32'h0000_0100);
    checkOutput("fetch k0 microcode", 32'(mem_microcode), 32'h6);
    checkOutput("fetch k0 mem_in", mem_in, 32'd0);
    waitCycle();
    checkOutput("fetch k1 enable_n", 32'(mem_enable_n), 32'd0);
    checkOutput("fetch k1 done", 32'(fetch_done), 32'd0);
    waitCycle();
    checkOutput("fetch k2 done", 32'(fetch_done), 32'd1);
    checkOutput("fetch k2 data", fetch_data, 32'h00A0_0093);
    checkOutput("fetch k2 fault", 32'(fetch_fault_num), 32'd0);
    checkOutput("fetch k2 enable_n", 32'(mem_enable_n), 32'd1);
    fetch_req = 1'b0;
    waitCycle();
    checkOutput("fetch k3 done", 32'(fetch_done), 32'd0);

    // Both requests held from reset: data, fetch, data, fetch
    #1 reset_n = 1'b0;
    applyStimulus(1, 32'h0000_1000, 1, 4'b0010, 32'h0000_2000, 32'h0000_0000, 0, 3'd0, 1);
    @(negedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      waitCycle();
      checkOutput("rr data_done", 32'(data_done), 32'(k == 2 || k == 10));
      checkOutput("rr fetch_done", 32'(fetch_done), 32'(k == 6 || k == 14));
      if (k == 4) checkOutput("rr second grant addr", mem_addr, 32'h0000_1000);
      if (k == 10) checkOutput("rr data_rdata", data_rdata, 32'hA5A5_2000);
      if (k == 14) checkOutput("rr fetch_data", fetch_data, 32'hA5A5_1000);
      if (k == 15) begin fetch_req = 1'b0; data_req = 1'b0; end
    end

    // Misaligned word store, fault 110
    applyStimulus(0, 32'h0000_1000, 1, 4'b1010, 32'h2000_0002, 32'hDEAD_BEEF, 0, 3'b110, 0);
    waitCycle();
    checkOutput("store mem_in", mem_in, 32'hDEAD_BEEF);
    checkOutput("store microcode", 32'(mem_microcode), 32'hA);
    checkOutput("store mem_addr", mem_addr, 32'h2000_0002);
    repeat (2) waitCycle();
    checkOutput("store data_done", 32'(data_done), 32'd1);
    checkOutput("store fault", 32'(data_fault_num), 32'd6);
    checkOutput("store fetch_data kept", fetch_data, 32'hA5A5_1000);
    checkOutput("store fetch_fault kept", 32'(fetch_fault_num), 32'd0);
    checkOutput("store fetch_done", 32'(fetch_done), 32'd0);
    data_req = 1'b0;
    waitCycle();

    // Load access fault, fault 101, then a fresh fetch in the next IDLE
    applyStimulus(0, 32'h0000_1000, 1, 4'b0010, 32'h4000_0000, 32'd0, 32'h1234_5678, 3'b101, 0);
    repeat (3) waitCycle();
    checkOutput("ldfault done", 32'(data_done), 32'd1);
    checkOutput("ldfault fault", 32'(data_fault_num), 32'd5);
    checkOutput("ldfault rdata", data_rdata, 32'h1234_5678);
    applyStimulus(1, 32'h0000_0200, 0, 4'b0010, 32'h4000_0000, 32'd0, 32'h0000_0013, 3'd0, 0);
    waitCycle();
    checkOutput("ldfault single pulse", 32'(data_done), 32'd0);
    waitCycle();
    checkOutput("next fetch addr", mem_addr, 32'h0000_0200);
    repeat (2) waitCycle();
    checkOutput("next fetch done", 32'(fetch_done), 32'd1);
    checkOutput("next fetch data", fetch_data, 32'h0000_0013);
    checkOutput("next fetch data_rdata kept", data_rdata, 32'h1234_5678);

    // Reset pulsed during CAPTURE
    applyStimulus(1, 32'h0000_0300, 0, 4'b0010, 32'd0, 32'd0, 32'h0000_0073, 3'd0, 0);
    repeat (3) waitCycle();
    checkOutput("pre-reset capture enable_n", 32'(mem_enable_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset enable_n", 32'(mem_enable_n), 32'd1);
    checkOutput("async reset fetch_data", fetch_data, 32'd0);
    checkOutput("async reset data_rdata", data_rdata, 32'd0);
    checkOutput("async reset data_fault", 32'(data_fault_num), 32'd0);
    checkOutput("async reset mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    checkOutput("reset held no done", 32'({fetch_done, data_done}), 32'd0);
    #1 reset_n = 1'b1;
    repeat (3) waitCycle();
    checkOutput("post-reset fetch_done", 32'(fetch_done), 32'd1);
    checkOutput("post-reset fetch_data", fetch_data, 32'h0000_0073);
    fetch_req = 1'b0;
    waitCycle();

    // data_addr and fields changed during ISSUE are ignored
    applyStimulus(0, 32'h0000_0300, 1, 4'b0010, 32'h3000_0010, 32'd0, 32'h0BAD_F00D, 3'd0, 0);
    waitCycle();
    checkOutput("hold k0 mem_addr", mem_addr, 32'h3000_0010);
    applyStimulus(0, 32'h0000_0300, 1, 4'b1001, 32'h5555_5555, 32'hFFFF_FFFF, 32'h0BAD_F00D, 3'd0, 0);
    waitCycle();
    checkOutput("hold k1 mem_addr", mem_addr, 32'h3000_0010);
    checkOutput("hold k1 microcode", 32'(mem_microcode), 32'h2);
    checkOutput("hold k1 mem_in", mem_in, 32'd0);
    waitCycle();
    checkOutput("hold k2 done", 32'(data_done), 32'd1);
    checkOutput("hold k2 mem_addr", mem_addr, 32'h3000_0010);
    checkOutput("hold k2 rdata", data_rdata, 32'h0BAD_F00D);
    data_req = 1'b0;
    repeat (2) waitCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the memory access unit. It shares the unit between the instruction-fetch port and the load/store data port. It runs the unit's two-cycle enable window, holds the unit's inputs stable for that window, captures the read data and fault number, and returns them to the granted requester with a one-cycle done pulse. Arbitration between the two ports is round-robin.

Parameters:
RESET_PRIORITY, 0, port favoured on the first contended grant after reset (0 = data port, 1 = fetch port).

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
fetch_req  input  1  fetch request (level)
fetch_addr  input  32  fetch address
fetch_done  output  1  one-cycle pulse: fetch result valid
fetch_data  output  32  fetched word
fetch_fault_num  output  3  fault number for the fetch (000 = none)
data_req  input  1  load/store request (level)
data_microcode  input  mem_microcode_t  is_write, is_unsigned, op_size
data_addr  input  32  load/store address
data_wdata  input  32  store data
data_done  output  1  one-cycle pulse: load/store result valid
data_rdata  output  32  load result (sign/zero-extended by the memory unit)
data_fault_num  output  3  fault number for the load/store (000 = none)
mem_enable_n  output  1  to memory unit enable_n
mem_microcode  output  mem_microcode_t  to memory unit
mem_addr  output  32  to memory unit addr
mem_in  output  32  to memory unit in
mem_out  input  32  from memory unit out
mem_fault_num  input  3  from memory unit fault_num

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: state = IDLE, mem_enable_n = 1, all mem_* and requester data/fault outputs = 0, both done = 0, priority pointer = RESET_PRIORITY.
- FSM states: IDLE -> ISSUE -> CAPTURE -> DONE -> IDLE.
- IDLE, no requests: stay in IDLE.
- IDLE, one request: grant that port.
- IDLE, both requests: grant the port named by the pointer, then set the pointer to the other port.
- IDLE, single uncontended grant: set the pointer to the non-granted port.
- Grant latching (on the IDLE grant edge): latch owner, mem_addr, mem_in and mem_microcode into registers.
  - Fetch microcode is fixed: is_write = 0, is_unsigned = 1, op_size = WORD.
  - Fetch mem_in = 0.
- ISSUE: mem_enable_n = 0. The memory unit registers data and fault on the edge leaving ISSUE.
- CAPTURE: mem_enable_n = 0. mem_fault_num is valid. On the exit edge, latch mem_out and mem_fault_num into the owner's result registers.
- DONE: mem_enable_n = 1 and the owner's done = 1 for exactly one cycle. Result registers hold until that port's next capture.
- Stable inputs: mem_microcode, mem_addr and mem_in come only from registers. They stay unchanged from the IDLE grant edge through DONE, so unit inputs are stable throughout the enable window.
- Latency: request seen in IDLE at cycle 0 -> done at cycle 3. Back-to-back throughput is one access per 4 cycles.
- Requester contract:
  - Hold req and request fields until done.
  - Drop req in the cycle after done, or keep it high to issue a new request.
  - req is sampled only in IDLE. Changes to request fields after the grant are ignored.
- Arbitration edge cases:
  - A request that arrives while the other port is being served waits. It is granted at the next IDLE.
  - When both ports are continuously asserted, grants strictly alternate.
- Faults:
  - The fault number is passed through unmodified, including misaligned and access faults.
  - Fault and data are reported together with done. A faulted access still completes normally.
  - The other port's outputs are unaffected.
- Reset mid-operation (any state): immediately return to IDLE with mem_enable_n = 1 and no done pulse. The in-flight access is dropped and the requester must re-request.
- Invariants:
  - At most one done per cycle.
  - mem_enable_n is never 0 in IDLE or DONE.

Test Plan:
- Fetch only: fetch_addr = 0x00000100, mem_out = 0x00A00093, fault 000 -> mem_enable_n low in cycles 1–2, fetch_done at cycle 3, fetch_data = 0x00A00093, fetch_fault_num = 000.
- Both requests held high from reset, RESET_PRIORITY = 0 -> grant order data, fetch, data, fetch. Done pulses spaced 4 cycles apart and alternating ports.
- Misaligned store (word op, data_addr = 0x20000002), memory returns 110 -> data_done with data_fault_num = 110; fetch outputs unchanged.
- Load access fault (addr = 0x40000000), memory returns 101 -> data_fault_num = 101 and data_done pulses once; the next IDLE accepts a new request.
- reset_n pulsed low during CAPTURE -> mem_enable_n = 1 asynchronously, no done pulse, all outputs 0. A re-asserted request completes 3 cycles after release.
- data_addr changed during ISSUE -> mem_addr unchanged through DONE.
